// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the EX->MEM boundary.
//   - XLEN and branch funct3 encodings
//   - writeback select (result_src) encoding
//   - buf_state_t: occupancy of the 2-entry skid buffer
//   - exmem_payload_t: everything carried from EX into MEM
//   - branch_cond(): condition evaluation from the ALU flags
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
  } exmem_payload_t;

  localparam int PAYLOAD_W = $bits(exmem_payload_t);

  // Encodings 010/011 are not branch conditions: never taken.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic       zero,
                                       input logic       lt,
                                       input logic       ltu);
    logic cond;
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// skid_buf: 2-entry valid/ready buffer with a registered in_ready.
//   clk, reset_n          clock / async active-low reset
//   in_valid/in_ready     upstream handshake (in_ready comes straight from a flop)
//   in_data [W]           upstream payload
//   out_valid/out_ready   downstream handshake (out_valid = head occupied)
//   out_data [W]          head payload, held stable while stalled
// The second (skid) entry absorbs the one transfer that can land while
// in_ready is still high from the previous cycle, so out_ready never needs
// a combinational path to in_ready.
module skid_buf
  import riscv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         push, pop;

  assign push = in_valid & ready_q;
  assign pop  = (state_q != EMPTY) & out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Payload storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Next-state and storage update
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_data;          // head leaves, newcomer takes its place
        end else if (push) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // ready_q is low here, so push cannot occur
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready for next cycle is decided from the next state, keeping it a flop.
    ready_d = (state_d != TWO);
  end

  // Outputs
  always_comb begin
    in_ready  = ready_q;
    out_valid = (state_q != EMPTY);
    out_data  = head_q;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline boundary with branch/jump resolution.
//   clk, reset_n                 clock / async active-low reset
//   ex_valid/ex_ready            EX handshake
//   ex_alu_result, ex_zero/lt/ltu ALU result and compare flags
//   ex_branch/jump/jalr, funct3  control-transfer kind and condition
//   ex_pc_target, ex_pc_plus4    PC+imm target and link value
//   ex_write_data, ex_rd, ex_reg_write, ex_mem_write, ex_result_src  payload
//   mem_valid/mem_ready, mem_*   MEM handshake and head-entry payload
//   redirect_valid/redirect_pc   one-cycle taken-transfer pulse + target;
//                                also flushes IF/ID and ID/EX
// Fetch always predicts not-taken, so every taken transfer redirects. While
// the redirect pulse is high, whatever EX presents is wrong-path: it is
// consumed (ex_ready forced high) but neither buffered nor evaluated.
module ex_mem_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_zero,
  input  logic            ex_lt,
  input  logic            ex_ltu,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc_target,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic [XLEN-1:0] ex_write_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_write,
  input  logic [1:0]      ex_result_src,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_write_data,
  output logic [XLEN-1:0] mem_pc_plus4,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_write,
  output logic [1:0]      mem_result_src,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            squash;
  logic            buf_in_ready;
  logic            accept;
  logic            taken;
  exmem_payload_t  in_pl, out_pl;

  assign squash   = redirect_valid_q;
  assign ex_ready = buf_in_ready | squash;
  // Only a non-squashed transfer is real; it is also what the buffer pushes.
  assign accept   = ex_valid & buf_in_ready & ~squash;

  always_comb begin
    in_pl            = '0;
    in_pl.alu_result = ex_alu_result;
    in_pl.write_data = ex_write_data;
    in_pl.pc_plus4   = ex_pc_plus4;
    in_pl.rd         = ex_rd;
    in_pl.reg_write  = ex_reg_write;
    in_pl.mem_write  = ex_mem_write;
    in_pl.result_src = ex_result_src;
  end

  skid_buf #(
    .W(PAYLOAD_W)
  ) u_skid_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (ex_valid & ~squash),
    .in_ready (buf_in_ready),
    .in_data  (in_pl),
    .out_valid(mem_valid),
    .out_ready(mem_ready),
    .out_data (out_pl)
  );

  assign mem_alu_result = out_pl.alu_result;
  assign mem_write_data = out_pl.write_data;
  assign mem_pc_plus4   = out_pl.pc_plus4;
  assign mem_rd         = out_pl.rd;
  assign mem_reg_write  = out_pl.reg_write;
  assign mem_mem_write  = out_pl.mem_write;
  assign mem_result_src = out_pl.result_src;

  // Branch/jump resolution
  always_comb begin
    taken = ex_jump | ex_jalr |
            (ex_branch & branch_cond(ex_funct3, ex_zero, ex_lt, ex_ltu));
    redirect_valid_d = accept & taken;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d) begin
      // JALR target must be halfword-aligned: clear bit 0 of rs1+imm.
      redirect_pc_d = ex_jalr ? {ex_alu_result[XLEN-1:1], 1'b0} : ex_pc_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  import riscv_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_alu_result;
  logic            ex_zero, ex_lt, ex_ltu;
  logic            ex_branch, ex_jump, ex_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc_target, ex_pc_plus4, ex_write_data;
  logic [4:0]      ex_rd;
  logic            ex_reg_write, ex_mem_write;
  logic [1:0]      ex_result_src;
  logic            mem_valid, mem_ready;
  logic [XLEN-1:0] mem_alu_result, mem_write_data, mem_pc_plus4;
  logic [4:0]      mem_rd;
  logic            mem_reg_write, mem_mem_write;
  logic [1:0]      mem_result_src;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result),
    .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_funct3(ex_funct3),
    .ex_pc_target(ex_pc_target), .ex_pc_plus4(ex_pc_plus4),
    .ex_write_data(ex_write_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
    .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_alu_result = '0; ex_zero = 0; ex_lt = 0; ex_ltu = 0;
    ex_branch = 0; ex_jump = 0; ex_jalr = 0; ex_funct3 = '0;
    ex_pc_target = '0; ex_pc_plus4 = '0; ex_write_data = '0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_write = 0; ex_result_src = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    mem_ready = 1;
    #1 reset_n = 0;
    tick(); tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    checks++; if ({mem_alu_result, mem_write_data, mem_pc_plus4, mem_rd} !== '0) begin errors++; $display("FAIL reset_payload: got nonzero expected 0"); end
    reset_n = 1;
    tick();
    $display("[%0t] reset: mem_valid=%b ex_ready=%b", $time, mem_valid, ex_ready);
  endtask

  task automatic test_beq_taken();
    clear_inputs(); mem_ready = 1;
    ex_valid = 1; ex_branch = 1; ex_funct3 = F3_BEQ; ex_zero = 1;
    ex_pc_target = 32'h100; ex_alu_result = 32'hAA;
    tick();
    $display("[%0t] beq: redirect_valid=%b redirect_pc=%h", $time, redirect_valid, redirect_pc);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_redirect_valid: got %b expected 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL beq_redirect_pc: got %h expected 100", redirect_pc); end
    checks++; if (mem_valid !== 1'b1 || mem_alu_result !== 32'hAA) begin errors++; $display("FAIL beq_at_mem: got valid=%b alu=%h expected 1/aa", mem_valid, mem_alu_result); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL beq_squash_ready: got %b expected 1", ex_ready); end
    // wrong-path instruction during the squash cycle (a jump, so evaluation would show)
    clear_inputs(); ex_valid = 1; ex_jump = 1; ex_alu_result = 32'hDEAD; ex_pc_target = 32'h500;
    tick();
    $display("[%0t] beq squash: redirect_valid=%b mem_valid=%b", $time, redirect_valid, mem_valid);
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_redirect_pulse: got %b expected 0", redirect_valid); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL beq_wrong_path_dropped: got mem_valid=%b alu=%h expected 0", mem_valid, mem_alu_result); end
    clear_inputs();
    tick();
  endtask

  task automatic test_bltu_not_taken();
    clear_inputs(); mem_ready = 1;
    ex_valid = 1; ex_branch = 1; ex_funct3 = F3_BLTU; ex_ltu = 0; ex_lt = 1; ex_zero = 1;
    ex_alu_result = 32'h1234_5678; ex_write_data = 32'hCAFE_BABE; ex_pc_plus4 = 32'h44;
    ex_pc_target = 32'h888; ex_rd = 5'd7; ex_reg_write = 1; ex_mem_write = 1; ex_result_src = RES_PC4;
    tick();
    clear_inputs();
    $display("[%0t] bltu: redirect=%b mem_valid=%b alu=%h", $time, redirect_valid, mem_valid, mem_alu_result);
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bltu_no_redirect: got %b expected 0", redirect_valid); end
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL bltu_mem_valid: got %b expected 1", mem_valid); end
    checks++; if (mem_alu_result !== 32'h1234_5678) begin errors++; $display("FAIL bltu_alu: got %h expected 12345678", mem_alu_result); end
    checks++; if (mem_write_data !== 32'hCAFE_BABE) begin errors++; $display("FAIL bltu_wdata: got %h expected cafebabe", mem_write_data); end
    checks++; if (mem_pc_plus4 !== 32'h44) begin errors++; $display("FAIL bltu_pc4: got %h expected 44", mem_pc_plus4); end
    checks++; if (mem_rd !== 5'd7 || mem_reg_write !== 1'b1 || mem_mem_write !== 1'b1 || mem_result_src !== 2'b10) begin
      errors++; $display("FAIL bltu_ctrl: got rd=%0d rw=%b mw=%b rs=%b expected 7/1/1/10", mem_rd, mem_reg_write, mem_mem_write, mem_result_src); end
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL bltu_drain: got %b expected 0", mem_valid); end
  endtask

  task automatic test_jalr();
    clear_inputs(); mem_ready = 1;
    ex_valid = 1; ex_jalr = 1; ex_alu_result = 32'h2003; ex_pc_plus4 = 32'h1004; ex_pc_target = 32'h9999;
    tick();
    clear_inputs();
    $display("[%0t] jalr: redirect=%b pc=%h mem_pc_plus4=%h", $time, redirect_valid, redirect_pc, mem_pc_plus4);
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL jalr_redirect_valid: got %b expected 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h2002) begin errors++; $display("FAIL jalr_redirect_pc: got %h expected 2002", redirect_pc); end
    checks++; if (mem_pc_plus4 !== 32'h1004 || mem_alu_result !== 32'h2003) begin
      errors++; $display("FAIL jalr_payload: got pc4=%h alu=%h expected 1004/2003", mem_pc_plus4, mem_alu_result); end
    tick();
    tick();
  endtask

  task automatic test_branch_conds();
    // {funct3[2:0], zero, lt, ltu, expected_taken}
    logic [6:0] vec [10];
    vec = '{7'b000_1_0_0_1, 7'b000_0_0_0_0, 7'b001_0_0_0_1, 7'b001_1_0_0_0,
            7'b100_0_1_0_1, 7'b101_0_1_0_0, 7'b110_0_0_0_0, 7'b111_0_0_0_1,
            7'b010_1_1_1_0, 7'b011_1_1_1_0};
    mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      ex_valid = 1; ex_branch = 1; ex_funct3 = vec[i][6:4];
      ex_zero = vec[i][3]; ex_lt = vec[i][2]; ex_ltu = vec[i][1];
      ex_pc_target = 32'h1000 + 32'(i * 4); ex_alu_result = 32'h500 + 32'(i);
      tick();
      clear_inputs();
      $display("[%0t] branch f3=%b: redirect=%b mem_valid=%b", $time, vec[i][6:4], redirect_valid, mem_valid);
      checks++; if (redirect_valid !== vec[i][0]) begin errors++; $display("FAIL cond_%0d_taken: got %b expected %b", i, redirect_valid, vec[i][0]); end
      checks++; if (mem_valid !== 1'b1 || mem_alu_result !== 32'h500 + 32'(i)) begin
        errors++; $display("FAIL cond_%0d_passes: got valid=%b alu=%h", i, mem_valid, mem_alu_result); end
      if (vec[i][0]) begin
        checks++; if (redirect_pc !== 32'h1000 + 32'(i * 4)) begin errors++; $display("FAIL cond_%0d_pc: got %h expected %h", i, redirect_pc, 32'h1000 + 32'(i * 4)); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic acc, del;
    clear_inputs();
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      mem_ready = (cyc >= 3);
      if (sent < 5) begin
        ex_valid = 1; ex_alu_result = 32'h10 + 32'(sent); ex_rd = 5'(sent + 1); ex_reg_write = 1;
      end else begin
        ex_valid = 0;
      end
      if (cyc == 2) begin
        checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL bp_ex_ready_low: got %b expected 0", ex_ready); end
        checks++; if (mem_valid !== 1'b1 || mem_alu_result !== 32'h10) begin errors++; $display("FAIL bp_head_stable: got valid=%b alu=%h expected 1/10", mem_valid, mem_alu_result); end
      end
      acc = ex_valid && ex_ready;
      del = mem_valid && mem_ready;
      if (del) begin
        $display("[%0t] bp deliver #%0d: alu=%h rd=%0d", $time, got, mem_alu_result, mem_rd);
        checks++; if (mem_alu_result !== 32'h10 + 32'(got) || mem_rd !== 5'(got + 1)) begin
          errors++; $display("FAIL bp_order_%0d: got alu=%h rd=%0d expected %h/%0d", got, mem_alu_result, mem_rd, 32'h10 + 32'(got), got + 1); end
      end
      tick();
      if (acc) sent++;
      if (del) got++;
    end
    clear_inputs();
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_all_delivered: got %0d expected 5", got); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", mem_valid); end
  endtask

  task automatic test_back_to_back();
    clear_inputs(); mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      ex_valid = 1; ex_alu_result = 32'h300 + 32'(i);
      tick();
      $display("[%0t] b2b %0d: mem_valid=%b alu=%h", $time, i, mem_valid, mem_alu_result);
      checks++; if (mem_valid !== 1'b1 || mem_alu_result !== 32'h300 + 32'(i) || ex_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d: got valid=%b alu=%h ready=%b expected 1/%h/1", i, mem_valid, mem_alu_result, ex_ready, 32'h300 + 32'(i)); end
    end
    clear_inputs();
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", mem_valid); end
  endtask

  // Fill both entries; the second is a taken JAL, so redirect is pending in TWO.
  task automatic fill_two_with_jump(input logic [31:0] base, input logic [31:0] tgt);
    clear_inputs(); mem_ready = 0;
    ex_valid = 1; ex_alu_result = base;
    tick();
    ex_jump = 1; ex_alu_result = base + 1; ex_pc_target = tgt;
    tick();
  endtask

  task automatic test_squash_in_two();
    fill_two_with_jump(32'h600, 32'h700);
    $display("[%0t] squash in TWO: redirect=%b ex_ready=%b", $time, redirect_valid, ex_ready);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h700) begin errors++; $display("FAIL sq2_redirect: got %b/%h expected 1/700", redirect_valid, redirect_pc); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL sq2_ready_override: got %b expected 1", ex_ready); end
    clear_inputs(); ex_valid = 1; ex_alu_result = 32'hBAD;
    tick();
    checks++; if (ex_ready !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL sq2_still_two: got ready=%b redirect=%b expected 0/0", ex_ready, redirect_valid); end
    checks++; if (mem_alu_result !== 32'h600) begin errors++; $display("FAIL sq2_head: got %h expected 600", mem_alu_result); end
    clear_inputs(); mem_ready = 1;
    tick();
    checks++; if (mem_valid !== 1'b1 || mem_alu_result !== 32'h601) begin errors++; $display("FAIL sq2_skid_to_head: got valid=%b alu=%h expected 1/601", mem_valid, mem_alu_result); end
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL sq2_no_wrong_path: got valid=%b alu=%h expected 0", mem_valid, mem_alu_result); end
  endtask

  task automatic test_reset_mid();
    fill_two_with_jump(32'h800, 32'h900);
    checks++; if (redirect_valid !== 1'b1 || mem_valid !== 1'b1) begin errors++; $display("FAIL rm_setup: got redirect=%b valid=%b expected 1/1", redirect_valid, mem_valid); end
    reset_n = 0;
    #1;
    $display("[%0t] reset mid-op: mem_valid=%b redirect=%b ex_ready=%b", $time, mem_valid, redirect_valid, ex_ready);
    checks++; if (mem_valid !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL rm_async: got valid=%b redirect=%b pc=%h expected 0/0/0", mem_valid, redirect_valid, redirect_pc); end
    checks++; if (ex_ready !== 1'b1 || mem_alu_result !== 32'h0) begin errors++; $display("FAIL rm_async_ready: got ready=%b alu=%h expected 1/0", ex_ready, mem_alu_result); end
    clear_inputs(); mem_ready = 1;
    tick();
    reset_n = 1;
    tick();
    checks++; if (ex_ready !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL rm_after_release: got ready=%b valid=%b expected 1/0", ex_ready, mem_valid); end
  endtask

  initial begin
    clear_inputs();
    mem_ready = 1;
    test_reset();
    test_beq_taken();
    test_bltu_not_taken();
    test_jalr();
    test_branch_conds();
    test_backpressure();
    test_back_to_back();
    test_squash_in_two();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX→MEM pipeline boundary of the pipelined core. It consumes the ALU result and flags (Zero, LessThan, LessThanUnsigned) with the EX-stage control word, and resolves conditional branches and jumps. It raises a registered redirect to fetch on a taken control transfer and buffers the instruction toward MEM through a 2-entry valid/ready skid buffer, so backpressure from MEM never needs a combinational path into EX.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  stage accepts this cycle
- ex_alu_result  in  XLEN  ALU result
- ex_zero, ex_lt, ex_ltu  in  1 each  ALU Zero / LessThan / LessThanUnsigned
- ex_branch, ex_jump, ex_jalr  in  1 each  conditional branch / JAL / JALR
- ex_funct3  in  3  branch condition
- ex_pc_target  in  XLEN  PC+imm (branch/JAL target)
- ex_pc_plus4  in  XLEN  link value
- ex_write_data  in  XLEN  store data
- ex_rd  in  5  destination register
- ex_reg_write, ex_mem_write  in  1 each  write enables
- ex_result_src  in  2  writeback select
- mem_valid  out  1  head entry valid
- mem_ready  in  1  MEM accepts head
- mem_alu_result, mem_write_data, mem_pc_plus4  out  XLEN each  head payload
- mem_rd  out  5; mem_reg_write, mem_mem_write  out  1 each; mem_result_src  out  2
- redirect_valid  out  1  one-cycle taken-transfer pulse; also the flush request for IF/ID and ID/EX
- redirect_pc  out  XLEN  redirect target

## Operation
- Accept = ex_valid & ex_ready; deliver = mem_valid & mem_ready.
- Taken evaluated only on a non-squashed accept:
  - ex_jump | ex_jalr → taken.
  - ex_branch: funct3 000 zero, 001 ~zero, 100 lt, 101 ~lt, 110 ltu, 111 ~ltu; 010/011 → not taken, but the instruction still passes.
- Target: JALR → {ex_alu_result[XLEN-1:1],1'b0}; otherwise ex_pc_target.
- Prediction is always not-taken, so every taken transfer redirects.
- Squash: in the cycle redirect_valid=1, the instruction presented by EX is wrong-path. ex_ready is forced to 1, the transfer is dropped (not buffered, not evaluated), and redirect_valid deasserts next cycle.
- Buffer FSM, state enum EMPTY/ONE/TWO:
  - EMPTY: accept → ONE.
  - ONE: accept & ~deliver → TWO; deliver & ~accept → EMPTY; both → ONE, head replaced.
  - TWO: deliver → ONE, skid entry moves to head; no accept possible.
- ex_ready is registered: 1 in EMPTY/ONE, 0 in TWO. A squash cycle overrides it to 1 even in TWO; the dropped transfer does not change state.
- Branches, and stores with mem_write=0, still flow to MEM. Only reg_write/mem_write qualify side effects.
- No arithmetic beyond target bit-0 clear; all payloads pass through at full width unchanged.

## Timing
- Reset, asynchronous: state EMPTY, mem_valid 0, all mem_* payloads 0, ex_ready 1, redirect_valid 0, redirect_pc 0.
- A reset mid-operation discards both entries and any pending redirect.
- Latency: accept at edge N → mem_valid=1 after edge N; redirect_valid/redirect_pc valid during cycle N+1 for exactly one cycle.
- Throughput is 1/cycle with mem_ready held high.
- mem_ready low for k cycles: at most 2 instructions held; ex_ready falls the cycle after the second accept.
- mem_* outputs are stable while mem_valid & ~mem_ready.
- Simultaneous accept+deliver in ONE is lossless; order is strictly FIFO.
- A taken instruction in TWO is impossible (no accept). A taken branch accepted while MEM stalls still redirects at N+1.

## Structure
- riscv_pkg holds: funct3 branch constants, result_src encoding, buf_state_t enum, and an exmem_payload_t packed struct (alu_result, write_data, pc_plus4, rd, reg_write, mem_write, result_src).
- One sub-module, skid_buf: a 2-entry valid/ready buffer parameterized on payload width, containing the FSM.
- Branch resolve and the redirect register live in ex_mem_stage.

## Test plan
- BEQ (funct3 000), ex_zero=1, ex_pc_target=0x100 → next cycle redirect_valid=1 and redirect_pc=0x100 for one cycle; the following EX instruction is dropped (never seen on mem_valid).
- BLTU with ex_ltu=0 → no redirect; instruction appears at MEM one cycle later with payload intact.
- JALR with ex_alu_result=0x2003 → redirect_pc=0x2002; mem_pc_plus4 equals ex_pc_plus4.
- Stream of 5 ALU ops, mem_ready low for 3 cycles → 2 buffered, ex_ready=0, no loss or reorder; the resumed output matches input order.
- Back-to-back accept+deliver with mem_ready=1 for 10 cycles → mem_valid continuous, 1-cycle latency each.
- reset_n asserted in state TWO with a pending redirect → outputs immediately at reset values; after release, ex_ready=1 and mem_valid=0.
